// File: rtl/morra_param_fsmd.sv
// morra_param_fsmd: two-player rock/paper/scissors game controller with a
// configurable game length, winning lead and optional winner-cannot-repeat rule.
// All outputs are registered; inputs sampled on one edge appear after it.
module morra_param_fsmd #(
  parameter int MIN_ROUNDS = 4,
  parameter int MAX_ROUNDS = 19,
  parameter int LEAD       = 2,
  parameter int NO_REPEAT  = 1,
  parameter int CW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    P1,
  input  logic [1:0]    P2,
  input  logic          START,
  output logic [1:0]    ROUND,
  output logic [1:0]    GAME,
  output logic [CW-1:0] ROUND_CNT,
  output logic [CW-1:0] SCORE1,
  output logic [CW-1:0] SCORE2
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  localparam logic [CW-1:0]        MIN_C  = CW'(MIN_ROUNDS);
  localparam logic signed [CW:0]   LEAD_S = (CW+1)'(LEAD);
  localparam logic [CW-1:0]        ONE_C  = CW'(1);

  state_t        state, nxt_state;
  logic [CW-1:0] limit;
  logic [1:0]    last_win;   // 01/10 = who won the previous valid round, 00 = none/tie
  logic [1:0]    last_move;  // move that winner won with

  logic          valid;
  logic [1:0]    res;
  logic [CW-1:0] cnt_upd, s1_upd, s2_upd;
  logic signed [CW:0] diff, mag;
  logic [1:0]    end_res;

  logic [1:0]    nxt_round, nxt_game, nxt_last_win, nxt_last_move;
  logic [CW-1:0] nxt_cnt, nxt_s1, nxt_s2, nxt_limit;

  // True when move a defeats move b (both non-zero and different)
  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b01 && b == 2'b11) ||
           (a == 2'b10 && b == 2'b01) ||
           (a == 2'b11 && b == 2'b10);
  endfunction

  // Game length from the extra-round nibble, saturated at MAX_ROUNDS
  function automatic logic [CW-1:0] sat_limit(input logic [3:0] extra);
    int t;
    t = MIN_ROUNDS + int'(extra);
    if (t > MAX_ROUNDS) t = MAX_ROUNDS;
    return CW'(t);
  endfunction

  // Evaluate the current round as if it were valid, using post-update scores
  always_comb begin
    valid = (P1 != 2'b00) && (P2 != 2'b00);
    if (NO_REPEAT != 0) begin
      if ((last_win == 2'b01 && P1 == last_move) ||
          (last_win == 2'b10 && P2 == last_move))
        valid = 1'b0;
    end
    if (P1 == P2)          res = 2'b11;
    else if (beats(P1, P2)) res = 2'b01;
    else                   res = 2'b10;
    cnt_upd = ROUND_CNT + ONE_C;
    s1_upd  = SCORE1 + ((res == 2'b01) ? ONE_C : '0);
    s2_upd  = SCORE2 + ((res == 2'b10) ? ONE_C : '0);
    diff    = $signed({1'b0, s1_upd}) - $signed({1'b0, s2_upd});
    mag     = (diff < 0) ? -diff : diff;
    if (cnt_upd >= MIN_C && mag >= LEAD_S)
      end_res = (diff > 0) ? 2'b01 : 2'b10;
    else if (cnt_upd == limit)
      end_res = (diff > 0) ? 2'b01 : ((diff < 0) ? 2'b10 : 2'b11);
    else
      end_res = 2'b00;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic: START always (re)enters PLAY, a decided round returns to IDLE
  always_comb begin
    nxt_state = state;
    if (START)
      nxt_state = PLAY;
    else if (state == PLAY && valid && end_res != 2'b00)
      nxt_state = IDLE;
  end

  // Next values of outputs, counters and last-winner record
  always_comb begin
    nxt_round     = 2'b00;
    nxt_game      = 2'b00;
    nxt_cnt       = ROUND_CNT;
    nxt_s1        = SCORE1;
    nxt_s2        = SCORE2;
    nxt_limit     = limit;
    nxt_last_win  = last_win;
    nxt_last_move = last_move;
    if (START) begin
      nxt_limit     = sat_limit({P1, P2});
      nxt_cnt       = '0;
      nxt_s1        = '0;
      nxt_s2        = '0;
      nxt_last_win  = 2'b00;
      nxt_last_move = 2'b00;
    end else if (state == PLAY && valid) begin
      nxt_round     = res;
      nxt_game      = end_res;
      nxt_cnt       = cnt_upd;
      nxt_s1        = s1_upd;
      nxt_s2        = s2_upd;
      nxt_last_win  = (res == 2'b11) ? 2'b00 : res;
      nxt_last_move = (res == 2'b01) ? P1 : ((res == 2'b10) ? P2 : 2'b00);
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ROUND     <= 2'b00;
      GAME      <= 2'b00;
      ROUND_CNT <= '0;
      SCORE1    <= '0;
      SCORE2    <= '0;
      limit     <= MIN_C;
      last_win  <= 2'b00;
      last_move <= 2'b00;
    end else begin
      ROUND     <= nxt_round;
      GAME      <= nxt_game;
      ROUND_CNT <= nxt_cnt;
      SCORE1    <= nxt_s1;
      SCORE2    <= nxt_s2;
      limit     <= nxt_limit;
      last_win  <= nxt_last_win;
      last_move <= nxt_last_move;
    end
  end

endmodule

// File: tb/tb_morra_param_fsmd.sv
// Bench for morra_param_fsmd: two instances (default parameters, and
// MAX_ROUNDS=10 with the repeat rule disabled) driven by the same stimulus;
// expected outputs come from a rule-level model and are checked via queues.
module tb_morra_param_fsmd;

  logic       clk, rst, START;
  logic [1:0] P1, P2;

  logic [1:0] round_a, game_a;
  logic [4:0] cnt_a, s1_a, s2_a;
  logic [1:0] round_b, game_b;
  logic [3:0] cnt_b, s1_b, s2_b;

  morra_param_fsmd dut_a (
    .clk(clk), .rst(rst), .P1(P1), .P2(P2), .START(START),
    .ROUND(round_a), .GAME(game_a), .ROUND_CNT(cnt_a), .SCORE1(s1_a), .SCORE2(s2_a)
  );

  morra_param_fsmd #(.MIN_ROUNDS(4), .MAX_ROUNDS(10), .LEAD(2), .NO_REPEAT(0)) dut_b (
    .clk(clk), .rst(rst), .P1(P1), .P2(P2), .START(START),
    .ROUND(round_b), .GAME(game_b), .ROUND_CNT(cnt_b), .SCORE1(s1_b), .SCORE2(s2_b)
  );

  typedef struct {
    bit play;
    int round, game, cnt, s1, s2, limit, lw, lm;
  } ms_t;

  ms_t ma, mb;
  ms_t qa[$];
  ms_t qb[$];
  int  n_vec = 0;
  int  n_cmp = 0;
  int  n_miss = 0;
  bit  stim_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rule-level model: moves 1..3 form a cycle where (a-b) mod 3 == 1 means a wins
  function automatic ms_t mnext(input ms_t s, input bit r, input bit st,
                                input int a, input int b,
                                input int minr, input int maxr, input int lead,
                                input int norep);
    ms_t n;
    int d, df, ad;
    bit ok;
    n = s;
    n.round = 0;
    n.game  = 0;
    if (r) begin
      n.play = 0; n.cnt = 0; n.s1 = 0; n.s2 = 0;
      n.limit = minr; n.lw = 0; n.lm = 0;
    end else if (st) begin
      n.limit = (minr + a * 4 + b > maxr) ? maxr : minr + a * 4 + b;
      n.cnt = 0; n.s1 = 0; n.s2 = 0; n.lw = 0; n.lm = 0;
      n.play = 1;
    end else if (s.play) begin
      ok = (a != 0) && (b != 0);
      if (norep != 0 && ((s.lw == 1 && a == s.lm) || (s.lw == 2 && b == s.lm)))
        ok = 0;
      if (ok) begin
        d = (a - b + 3) % 3;
        if (d == 0) begin
          n.round = 3; n.lw = 0; n.lm = 0;
        end else if (d == 1) begin
          n.round = 1; n.s1 = s.s1 + 1; n.lw = 1; n.lm = a;
        end else begin
          n.round = 2; n.s2 = s.s2 + 1; n.lw = 2; n.lm = b;
        end
        n.cnt = s.cnt + 1;
        df = n.s1 - n.s2;
        ad = (df < 0) ? -df : df;
        if (n.cnt >= minr && ad >= lead)
          n.game = (df > 0) ? 1 : 2;
        else if (n.cnt == n.limit)
          n.game = (df > 0) ? 1 : ((df < 0) ? 2 : 3);
        if (n.game != 0) n.play = 0;
      end
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit st, input logic [1:0] a, input logic [1:0] b);
    rst = r; START = st; P1 = a; P2 = b;
    ma = mnext(ma, r, st, int'(a), int'(b), 4, 19, 2, 1);
    mb = mnext(mb, r, st, int'(a), int'(b), 4, 10, 2, 0);
    qa.push_back(ma);
    qb.push_back(mb);
    n_vec++;
    @(negedge clk);
  endtask

  task automatic mv(input logic [1:0] a, input logic [1:0] b);
    step(1'b0, 1'b0, a, b);
  endtask

  task automatic chk(input string nm, input ms_t e, input int r, input int g,
                     input int c, input int x1, input int x2);
    n_cmp++;
    if (r != e.round || g != e.game || c != e.cnt || x1 != e.s1 || x2 != e.s2) begin
      n_miss++;
      $display("FAIL %s @%0t round/game/cnt/s1/s2 got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
               nm, $time, r, g, c, x1, x2, e.round, e.game, e.cnt, e.s1, e.s2);
    end
  endtask

  // Monitor: outputs are presented every cycle, checked just after the edge
  initial begin
    ms_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("dut_a", e, int'(round_a), int'(game_a), int'(cnt_a), int'(s1_a), int'(s2_a));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("dut_b", e, int'(round_b), int'(game_b), int'(cnt_b), int'(s1_b), int'(s2_b));
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized play
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    // reset with START and moves asserted
    step(1, 1, 2'b01, 2'b01);
    step(1, 1, 2'b01, 2'b01);
    // lead win with default length
    step(0, 1, 2'b00, 2'b00);
    mv(2'b01, 2'b11); mv(2'b10, 2'b01); mv(2'b11, 2'b11); mv(2'b01, 2'b01);
    mv(2'b01, 2'b10);
    // repeat rule
    step(0, 1, 2'b00, 2'b00);
    mv(2'b01, 2'b11); mv(2'b01, 2'b10); mv(2'b11, 2'b11); mv(2'b01, 2'b10);
    // length 5 ending in a draw
    step(0, 1, 2'b00, 2'b01);
    mv(2'b01, 2'b11); mv(2'b01, 2'b10); mv(2'b11, 2'b11); mv(2'b10, 2'b10); mv(2'b01, 2'b01);
    // saturated length: all ties until the cap
    step(0, 1, 2'b11, 2'b11);
    for (int i = 0; i < 21; i++) mv(2'b10, 2'b10);
    // idle ignores moves
    mv(2'b01, 2'b10); mv(2'b11, 2'b01);
    // invalid move in play, then abort at three rounds
    step(0, 1, 2'b00, 2'b10);
    mv(2'b00, 2'b10); mv(2'b11, 2'b11); mv(2'b01, 2'b01); mv(2'b10, 2'b10);
    step(0, 1, 2'b00, 2'b00);
    mv(2'b01, 2'b11); mv(2'b10, 2'b10);
    // reset mid-game, then moves are ignored
    step(1, 0, 2'b01, 2'b10);
    mv(2'b01, 2'b10); mv(2'b10, 2'b11);
    // START in the same cycle as a would-be game-ending round
    step(0, 1, 2'b00, 2'b00);
    mv(2'b01, 2'b11); mv(2'b11, 2'b10); mv(2'b10, 2'b10);
    step(0, 1, 2'b01, 2'b11);
    // randomized play
    for (int i = 0; i < 3000; i++) begin
      bit r, st;
      logic [1:0] a, b;
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 29) == 0);
      a  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      b  = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      if (st && $urandom_range(0, 1) == 0) begin
        a = 2'($urandom_range(0, 3));
        b = 2'($urandom_range(0, 3));
      end
      step(r, st, a, b);
    end
    step(0, 0, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending a=%0d b=%0d expected 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
